bp_mem_pipelined_ram: RTL and testbench

- Synthesisable, parametrised test memory on the CCE-MEM interface. Successor to the single-outstanding DPI DRAM model.
- Accepts one command per cycle and keeps up to max_outstanding_p commands in flight.
- Each command has a fixed, configurable latency. Responses return strictly in order.
- Adds non-cacheable sub-word writes (byte merge) and needs no external simulator library. Used in ME and full-system testbenches.

---
 rtl/bp_mem_pkg.sv | 16 +
 rtl/bp_mem_pipelined_ram_fifo.sv | 47 ++++
 rtl/bp_mem_pipelined_ram.sv | 107 ++++++++++
 tb/tb_bp_mem_pipelined_ram.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/bp_mem_pkg.sv
// bp_mem_pkg: nc size/entry-kind types and the sub-word extract/merge helpers for bp_mem_pipelined_ram
package bp_mem_pkg;
  typedef enum logic [1:0] {e_nc_1b = 2'd0, e_nc_2b = 2'd1, e_nc_4b = 2'd2, e_nc_8b = 2'd3} bp_mem_nc_size_e;
  typedef enum logic {e_rd = 1'b0, e_wr = 1'b1} bp_mem_kind_e;
  function automatic logic [63:0] nc_mask(bp_mem_nc_size_e size);
    return size == e_nc_1b ? 64'hff : size == e_nc_2b ? 64'hffff : size == e_nc_4b ? 64'hffff_ffff : size == e_nc_8b ? '1 : '0;
  endfunction
  function automatic logic [63:0] nc_extract(logic [63:0] word, logic [2:0] byte_off, bp_mem_nc_size_e size);
    return (word >> {byte_off, 3'b0}) & nc_mask(size);
  endfunction
  function automatic logic [63:0] nc_merge(logic [63:0] word, logic [63:0] data, logic [2:0] byte_off, bp_mem_nc_size_e size);
    logic [63:0] m;
    m = nc_mask(size) << {byte_off, 3'b0};
    return (word & ~m) | ((data << {byte_off, 3'b0}) & m);
  endfunction
endpackage

// File: rtl/bp_mem_pipelined_ram_fifo.sv
// bp_mem_pipelined_ram_fifo: in-order queue whose slots each count down a fixed latency (enq/deq in, head data + ripe out)
module bp_mem_pipelined_ram_fifo #(
  parameter int width_p = 8,
  parameter int els_p = 4,
  parameter int latency_p = 4
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               enq_i,
  input  logic [width_p-1:0] data_i,
  input  logic               deq_i,
  output logic               full_o,
  output logic               v_o,
  output logic               ripe_o,
  output logic [width_p-1:0] data_o
);
  localparam int pw = els_p > 1 ? $clog2(els_p) : 1;
  localparam int cw = $clog2(latency_p + 1);
  localparam int nw = $clog2(els_p + 1);
  logic [width_p-1:0] mem_q [els_p];
  logic [cw-1:0] cnt_q [els_p];
  logic [pw-1:0] rptr_q, wptr_q;
  logic [nw-1:0] num_q;
  function automatic logic [pw-1:0] nxt(logic [pw-1:0] p);
    return p == pw'(els_p - 1) ? '0 : p + 1'b1;
  endfunction
  always_ff @(posedge clk_i)
    if (enq_i) mem_q[wptr_q] <= data_i;
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rptr_q <= '0;
      wptr_q <= '0;
      num_q <= '0;
      for (int i = 0; i < els_p; i++) cnt_q[i] <= '0;
    end else begin
      wptr_q <= enq_i ? nxt(wptr_q) : wptr_q;
      rptr_q <= deq_i ? nxt(rptr_q) : rptr_q;
      num_q <= num_q + nw'(enq_i) - nw'(deq_i);
      for (int i = 0; i < els_p; i++)
        cnt_q[i] <= (enq_i && wptr_q == pw'(i)) ? cw'(latency_p - 1) : cnt_q[i] - cw'(cnt_q[i] != '0);
    end
  end
  assign v_o = num_q != '0;
  assign full_o = num_q == nw'(els_p);
  assign ripe_o = cnt_q[rptr_q] == '0;
  assign data_o = mem_q[rptr_q];
endmodule

// File: rtl/bp_mem_pipelined_ram.sv
// bp_mem_pipelined_ram: pipelined block memory on CCE-MEM; cmd/data_cmd in (valid-yumi), resp/data_resp out (ready->valid), fixed latency, in order
module bp_mem_pipelined_ram import bp_mem_pkg::*; #(
  parameter int paddr_width_p = 40,
  parameter int num_lce_p = 2,
  parameter int lce_assoc_p = 8,
  parameter int block_size_in_bytes_p = 64,
  parameter int lce_req_data_width_p = 64,
  parameter int mem_els_p = 512,
  parameter int mem_latency_p = 4,
  parameter int max_outstanding_p = 4,
  localparam int block_size_in_bits_lp = 8 * block_size_in_bytes_p,
  localparam int payload_width_lp = (num_lce_p > 1 ? $clog2(num_lce_p) : 1) + (lce_assoc_p > 1 ? $clog2(lce_assoc_p) : 1),
  localparam int hdr_width_lp = 3 + paddr_width_p + payload_width_lp + 1 + 2,
  localparam int bp_cce_mem_cmd_width_lp = hdr_width_lp,
  localparam int bp_cce_mem_data_cmd_width_lp = hdr_width_lp + block_size_in_bits_lp,
  localparam int bp_mem_cce_resp_width_lp = hdr_width_lp,
  localparam int bp_mem_cce_data_resp_width_lp = hdr_width_lp + block_size_in_bits_lp
) (
  input  logic                                     clk_i,
  input  logic                                     reset_i,
  input  logic [bp_cce_mem_cmd_width_lp-1:0]       mem_cmd_i,
  input  logic                                     mem_cmd_v_i,
  output logic                                     mem_cmd_yumi_o,
  input  logic [bp_cce_mem_data_cmd_width_lp-1:0]  mem_data_cmd_i,
  input  logic                                     mem_data_cmd_v_i,
  output logic                                     mem_data_cmd_yumi_o,
  output logic [bp_mem_cce_resp_width_lp-1:0]      mem_resp_o,
  output logic                                     mem_resp_v_o,
  input  logic                                     mem_resp_ready_i,
  output logic [bp_mem_cce_data_resp_width_lp-1:0] mem_data_resp_o,
  output logic                                     mem_data_resp_v_o,
  input  logic                                     mem_data_resp_ready_i
);
  localparam int off_w = $clog2(block_size_in_bytes_p);
  localparam int idx_w = $clog2(mem_els_p);
  localparam int wo_w = $clog2(lce_req_data_width_p / 8);
  localparam int ww = lce_req_data_width_p;
  typedef struct packed {
    logic [2:0]                  msg_type;
    logic [paddr_width_p-1:0]    addr;
    logic [payload_width_lp-1:0] payload;
    logic                        non_cacheable;
    bp_mem_nc_size_e             nc_size;
  } hdr_s;
  typedef struct packed {
    bp_mem_kind_e                     kind;
    hdr_s                             hdr;
    logic [block_size_in_bits_lp-1:0] data;
  } entry_s;
  hdr_s cmd_hdr, wr_hdr;
  logic [block_size_in_bits_lp-1:0] wr_data, rd_blk, wr_old, wr_blk;
  logic [block_size_in_bits_lp-1:0] mem_q [mem_els_p];
  logic [idx_w-1:0] rd_idx, wr_idx;
  logic [off_w-wo_w-1:0] rd_ws, wr_ws;
  logic [ww-1:0] rd_word, wr_word;
  logic full, q_full, q_v, q_ripe, deq, enq;
  logic [$bits(entry_s)-1:0] q_data;
  entry_s enq_entry, head;
  assign cmd_hdr = hdr_s'(mem_cmd_i);
  assign {wr_hdr, wr_data} = mem_data_cmd_i;
  assign rd_idx = cmd_hdr.addr[off_w +: idx_w];
  assign wr_idx = wr_hdr.addr[off_w +: idx_w];
  assign rd_ws = cmd_hdr.addr[off_w-1:wo_w];
  assign wr_ws = wr_hdr.addr[off_w-1:wo_w];
  assign rd_blk = mem_q[rd_idx];
  assign rd_word = rd_blk[rd_ws*ww +: ww];
  assign wr_old = mem_q[wr_idx];
  assign wr_word = nc_merge(wr_old[wr_ws*ww +: ww], wr_data[ww-1:0], wr_hdr.addr[wo_w-1:0], wr_hdr.nc_size);
  always_comb begin
    wr_blk = wr_old;
    wr_blk[wr_ws*ww +: ww] = wr_word;
  end
  always_ff @(posedge clk_i)
    if (mem_data_cmd_yumi_o) mem_q[wr_idx] <= wr_hdr.non_cacheable ? wr_blk : wr_data;
  // a full queue still accepts when its head leaves in the same cycle
  assign q_full = full & ~deq;
  assign mem_data_cmd_yumi_o = ~reset_i & mem_data_cmd_v_i & ~q_full;
  assign mem_cmd_yumi_o = ~reset_i & mem_cmd_v_i & ~mem_data_cmd_v_i & ~q_full;
  assign enq = mem_cmd_yumi_o | mem_data_cmd_yumi_o;
  assign enq_entry = '{
    kind: mem_data_cmd_yumi_o ? e_wr : e_rd,
    hdr: mem_data_cmd_yumi_o ? wr_hdr : cmd_hdr,
    data: mem_data_cmd_yumi_o ? '0 : cmd_hdr.non_cacheable
      ? block_size_in_bits_lp'(nc_extract(rd_word, cmd_hdr.addr[wo_w-1:0], cmd_hdr.nc_size)) : rd_blk
  };
  bp_mem_pipelined_ram_fifo #(
    .width_p($bits(entry_s)),
    .els_p(max_outstanding_p),
    .latency_p(mem_latency_p)
  ) fifo (
    .clk_i(clk_i),
    .reset_i(reset_i),
    .enq_i(enq),
    .data_i(enq_entry),
    .deq_i(deq),
    .full_o(full),
    .v_o(q_v),
    .ripe_o(q_ripe),
    .data_o(q_data)
  );
  assign head = entry_s'(q_data);
  assign mem_data_resp_v_o = ~reset_i & q_v & q_ripe & (head.kind == e_rd) & mem_data_resp_ready_i;
  assign mem_resp_v_o = ~reset_i & q_v & q_ripe & (head.kind == e_wr) & mem_resp_ready_i;
  assign deq = mem_resp_v_o | mem_data_resp_v_o;
  assign mem_resp_o = mem_resp_v_o ? head.hdr : '0;
  assign mem_data_resp_o = mem_data_resp_v_o ? {head.hdr, head.data} : '0;
endmodule

// File: tb/tb_bp_mem_pipelined_ram.sv
// tb_bp_mem_pipelined_ram: directed and random traffic checked every cycle against a transaction-level model
module tb_bp_mem_pipelined_ram;
  localparam int L = 4, D = 4;
  typedef struct {
    bit rd;
    logic [49:0] hdr;
    logic [511:0] data;
    int rdy;
  } ent_t;
  logic clk = 0, rst = 1;
  logic [49:0] cmd_hdr = '0, wr_hdr = '0;
  logic [511:0] wr_data = '0;
  logic cmd_v = 0, dcmd_v = 0, r_rdy = 1, dr_rdy = 1;
  logic cmd_yumi, dcmd_yumi, resp_v, dresp_v;
  logic [49:0] resp;
  logic [561:0] dresp;
  int n_chk = 0, n_pass = 0, cyc_n = 0;
  logic [511:0] mdl [512];
  ent_t q[$];
  bit acc;
  logic [511:0] last_dr = '0;
  always #5 clk = ~clk;
  bp_mem_pipelined_ram dut (
    .clk_i(clk),
    .reset_i(rst),
    .mem_cmd_i(cmd_hdr),
    .mem_cmd_v_i(cmd_v),
    .mem_cmd_yumi_o(cmd_yumi),
    .mem_data_cmd_i({wr_hdr, wr_data}),
    .mem_data_cmd_v_i(dcmd_v),
    .mem_data_cmd_yumi_o(dcmd_yumi),
    .mem_resp_o(resp),
    .mem_resp_v_o(resp_v),
    .mem_resp_ready_i(r_rdy),
    .mem_data_resp_o(dresp),
    .mem_data_resp_v_o(dresp_v),
    .mem_data_resp_ready_i(dr_rdy)
  );
  task automatic chk(input string tag, input logic [575:0] got, input logic [575:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got=%0h exp=%0h", tag, cyc_n, got, exp);
  endtask
  function automatic logic [511:0] rd_model(logic [49:0] h);
    logic [39:0] a;
    logic [511:0] b, r;
    a = h[46:7];
    b = mdl[a[14:6]];
    r = '0;
    if (!h[2]) return b;
    for (int i = 0; i < (1 << h[1:0]); i++) r[8*i +: 8] = b[8*(a[5:0]+i) +: 8];
    return r;
  endfunction
  function automatic void wr_model(logic [49:0] h, logic [511:0] d);
    logic [39:0] a;
    logic [511:0] b;
    a = h[46:7];
    b = mdl[a[14:6]];
    if (h[2]) for (int i = 0; i < (1 << h[1:0]); i++) b[8*(a[5:0]+i) +: 8] = d[8*i +: 8];
    else b = d;
    mdl[a[14:6]] = b;
  endfunction
  function automatic logic [49:0] mk(logic [39:0] a, bit nc, logic [1:0] sz);
    return {3'($urandom), a, 4'($urandom), nc, sz};
  endfunction
  function automatic logic [511:0] rnd512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction
  function automatic logic [49:0] rnd_hdr();
    logic [1:0] sz;
    logic [5:0] off;
    sz = 2'($urandom_range(3));
    off = 6'($urandom) & ~6'((1 << sz) - 1);
    return mk({25'($urandom), 5'd0, 4'($urandom), off}, bit'($urandom_range(1)), sz);
  endfunction
  task automatic cyc();
    bit deq, dy, cy, dv, rv;
    logic [49:0] er;
    logic [561:0] ed;
    @(negedge clk);
    {deq, dv, rv} = '0;
    er = '0;
    ed = '0;
    if (!rst && q.size() > 0 && cyc_n >= q[0].rdy) begin
      dv = q[0].rd && dr_rdy;
      rv = !q[0].rd && r_rdy;
      deq = dv || rv;
      if (rv) er = q[0].hdr;
      if (dv) ed = {q[0].hdr, q[0].data};
    end
    dy = !rst && dcmd_v && (q.size() < D || deq);
    cy = !rst && cmd_v && !dcmd_v && (q.size() < D || deq);
    chk("data_cmd_yumi", dcmd_yumi, dy);
    chk("cmd_yumi", cmd_yumi, cy);
    chk("resp_v", resp_v, rv);
    chk("data_resp_v", dresp_v, dv);
    chk("resp", resp, er);
    chk("data_resp", dresp, ed);
    acc = cmd_yumi | dcmd_yumi;
    if (dresp_v) last_dr = dresp[511:0];
    if (rst) q.delete();
    else begin
      if (deq) void'(q.pop_front());
      if (dy) begin
        wr_model(wr_hdr, wr_data);
        q.push_back('{rd: 0, hdr: wr_hdr, data: '0, rdy: cyc_n + L});
      end
      if (cy) q.push_back('{rd: 1, hdr: cmd_hdr, data: rd_model(cmd_hdr), rdy: cyc_n + L});
    end
    cyc_n++;
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask
  task automatic send(input bit wr, input logic [39:0] a, input bit nc, input logic [1:0] sz, input logic [511:0] d);
    int n;
    n = 0;
    if (wr) begin
      wr_hdr = mk(a, nc, sz);
      wr_data = d;
      dcmd_v = 1;
    end else begin
      cmd_hdr = mk(a, nc, sz);
      cmd_v = 1;
    end
    do begin
      cyc();
      n++;
    end while (!acc && n < 64);
    chk("send_accepted", acc, 1'b1);
    cmd_v = 0;
    dcmd_v = 0;
  endtask
  initial begin
    int n;
    for (int i = 0; i < 512; i++) mdl[i] = '0;
    #1;
    idle(3);
    rst = 0;
    send(1, 40'h40, 0, 0, {64{8'hA5}});
    send(0, 40'h40, 0, 0, '0);
    idle(6);
    chk("t1_data", last_dr, {64{8'hA5}});
    wr_hdr = mk(40'h80, 0, 0);
    wr_data = {64{8'h5A}};
    cmd_hdr = mk(40'h80, 0, 0);
    dcmd_v = 1;
    cmd_v = 1;
    cyc();
    dcmd_v = 0;
    n = 0;
    do begin
      cyc();
      n++;
    end while (!acc && n < 64);
    chk("t3_rd_accepted", acc, 1'b1);
    cmd_v = 0;
    idle(6);
    chk("t3_data", last_dr, {64{8'h5A}});
    send(1, 40'h40, 0, 0, {64{8'h11}});
    send(1, 40'h46, 1, 1, 512'hBEEF);
    send(0, 40'h40, 1, 3, '0);
    idle(6);
    chk("t4_nc8", last_dr, 512'hBEEF111111111111);
    send(0, 40'h47, 1, 0, '0);
    idle(6);
    chk("t4_nc1", last_dr, 512'hBE);
    for (int i = 0; i < 5; i++) send(0, i[0] ? 40'h80 : 40'h40, 0, 0, '0);
    idle(8);
    dr_rdy = 0;
    send(0, 40'h80, 0, 0, '0);
    send(1, 40'hC0, 0, 0, rnd512());
    idle(10);
    dr_rdy = 1;
    idle(6);
    for (int i = 0; i < 3; i++) send(0, 40'h40, 0, 0, '0);
    rst = 1;
    cyc();
    rst = 0;
    idle(8);
    send(0, 40'h80, 0, 0, '0);
    idle(6);
    chk("t6_data", last_dr, {64{8'h5A}});
    for (int b = 0; b < 16; b++) send(1, {25'($urandom), 5'd0, 4'(b), 6'd0}, 0, 0, rnd512());
    for (int k = 0; k < 1500; k++) begin
      rst = $urandom_range(199) == 0;
      cmd_v = $urandom_range(2) != 0;
      dcmd_v = $urandom_range(2) == 0;
      r_rdy = $urandom_range(3) != 0;
      dr_rdy = $urandom_range(3) != 0;
      cmd_hdr = rnd_hdr();
      wr_hdr = rnd_hdr();
      wr_data = rnd512();
      cyc();
    end
    {rst, cmd_v, dcmd_v} = '0;
    {r_rdy, dr_rdy} = 2'b11;
    idle(20);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
